// File: rtl/elastic_seq_source.sv
// elastic_seq_source: accepts one (start, count) command on a valid/ready channel and emits
// count tokens start, start+STEP, ... on a valid/ready output channel, flagging the final
// token with outs_last. A new command can be taken on the cycle the last token transfers,
// so back-to-back sequences stream with no bubble.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_start, cmd_count  command payload (first value, number of tokens)
//   cmd_valid, cmd_ready  command handshake
//   outs, outs_last       output payload and end-of-sequence flag
//   outs_valid, outs_ready output handshake
module elastic_seq_source #(
  parameter int unsigned     DATA_TYPE   = 32,
  parameter int unsigned     COUNT_WIDTH = 8,
  parameter longint unsigned STEP        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_TYPE-1:0]   cmd_start,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [DATA_TYPE-1:0]   outs,
  output logic                   outs_last,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  localparam logic [DATA_TYPE-1:0] StepVal = DATA_TYPE'(STEP);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [DATA_TYPE-1:0]   value_q, value_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

  logic cmd_fire;
  logic out_fire;
  logic cmd_nonzero;

  always_comb begin
    outs       = value_q;
    outs_valid = (state_q == StEmit);
    outs_last  = (state_q == StEmit) && (remaining_q == COUNT_WIDTH'(1));
    // Ready combinationally follows outs_ready on the last token to avoid a bubble.
    cmd_ready  = (state_q == StIdle) || (outs_last && outs_ready);
  end

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign out_fire    = outs_valid && outs_ready;
  assign cmd_nonzero = (cmd_count != '0);

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        // A zero-count command is consumed without emitting anything.
        if (cmd_fire && cmd_nonzero) begin
          value_d     = cmd_start;
          remaining_d = cmd_count;
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (out_fire) begin
          if (remaining_q > COUNT_WIDTH'(1)) begin
            value_d     = value_q + StepVal;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
          end else if (cmd_fire && cmd_nonzero) begin
            value_d     = cmd_start;
            remaining_d = cmd_count;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      value_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: doc/elastic_seq_source.md
Name: elastic_seq_source

Overview:
- Elastic transmitter: accepts one command token (start value, count) on a valid/ready input channel.
- Emits `count` data tokens on a valid/ready output channel: start, start+STEP, start+2·STEP, …
- Flags the final token with `outs_last`.
- Sits upstream of elastic buffers/FIFOs as a sequence generator (loop index streams, address streams) and drives the same handshake they consume.

Parameters:
- DATA_TYPE, 32, width of start value and emitted data.
- COUNT_WIDTH, 8, width of the token count; max count = 2^COUNT_WIDTH−1.
- STEP, 1, increment added between consecutive tokens; truncated to DATA_TYPE bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_start  in  DATA_TYPE  first value of the sequence.
- cmd_count  in  COUNT_WIDTH  number of tokens to emit.
- cmd_valid  in  1  command token present.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- outs  out  DATA_TYPE  emitted data token.
- outs_last  out  1  high on the final token of a sequence.
- outs_valid  out  1  output token present.
- outs_ready  in  1  downstream accepts token.

Behaviour:
- Single clock; reset is synchronous and active-high (ports clk, rst).
- Registers:
  - state {IDLE, EMIT}
  - value [DATA_TYPE]
  - remaining [COUNT_WIDTH]
- Reset values: state=IDLE, value=0, remaining=0. Hence outs_valid=0, outs=0, outs_last=0, cmd_ready=1 after reset.
- Combinational outputs:
  - outs = value.
  - outs_valid = (state==EMIT).
  - outs_last = (state==EMIT) & (remaining==1).
  - cmd_ready = (state==IDLE) | (outs_last & outs_ready). This path is combinational from outs_ready, by design.
- Transfers: cmd_fire = cmd_valid & cmd_ready; out_fire = outs_valid & outs_ready.
- IDLE transitions:
  - cmd_fire with cmd_count≠0: value<=cmd_start, remaining<=cmd_count, state<=EMIT. First token is valid the next cycle (latency 1).
  - cmd_fire with cmd_count==0: command consumed, nothing emitted, stay IDLE.
- EMIT, out_fire with remaining>1: value<=value+STEP (mod 2^DATA_TYPE, wrap silently), remaining<=remaining−1, stay EMIT.
- EMIT, out_fire with remaining==1 (last):
  - With cmd_fire and cmd_count≠0: load the new command and stay EMIT. Zero bubble between sequences.
  - With cmd_fire and cmd_count==0: state<=IDLE.
  - Without cmd_fire: state<=IDLE.
- EMIT, no out_fire: all registers hold. outs/outs_last stay stable while outs_valid & ~outs_ready (protocol requirement).
- outs_valid never deasserts without a transfer, except on reset.
- Throughput: 1 token/cycle with outs_ready held high, including across command boundaries.
- In IDLE, value holds the last emitted value; outs is don't-care there.
- Reset mid-sequence: remaining tokens are discarded; next cycle outs_valid=0, cmd_ready=1.
- No backpressure on the output channel while IDLE; the command is the only input.

Test Plan:
- cmd_start=10, cmd_count=3, outs_ready=1 → cmd accepted at cycle 0; outs=10,11,12 at cycles 1–3; outs_last only with 12; outs_valid=0 at cycle 4.
- Same command, outs_ready toggled 1,0,0,1,1 → outs holds 11 stable through both stall cycles; exactly 3 transfers; last on 12.
- cmd_count=0, start=5 → cmd_ready=1, command consumed; outs_valid stays 0; a following command (7,1) emits a single 7 with outs_last=1.
- Back-to-back: (0,2) then (100,2) with cmd_valid held and outs_ready=1 → outs=0,1,100,101 on 4 consecutive cycles; cmd_ready high on the cycle of token 1; outs_last on 1 and 101.
- Wrap: start=0xFFFFFFFE, count=3, STEP=1 → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with last on 0; separately count=255 emits exactly 255 tokens.
- Start (20,10); assert rst for 1 cycle after 4 tokens → outs_valid=0, cmd_ready=1 on the following cycle; no further tokens; a new command (50,1) emits 50.
